hid_cmd_sender: RTL and testbench

// Initiator side of the HID byte protocol: serialises keyboard, mouse and joystick events into

---
 rtl/hid_cmd_sender_pkg.sv | 45 ++++
 rtl/hid_cmd_sender_pacer.sv | 34 +++
 rtl/hid_cmd_sender.sv | 201 ++++++++++++++++++++
 tb/tb_hid_cmd_sender.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hid_cmd_sender_pkg.sv
// Shared protocol constants, FSM encoding and frame payload type for hid_cmd_sender.
package hid_cmd_sender_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PAY_MAX = 5;
  localparam int unsigned IDX_W   = 3;

  localparam logic [BYTE_W-1:0] CMD_STATUS     = 8'd0;
  localparam logic [BYTE_W-1:0] CMD_KBD        = 8'd1;
  localparam logic [BYTE_W-1:0] CMD_MOUSE      = 8'd2;
  localparam logic [BYTE_W-1:0] CMD_JOY        = 8'd3;
  localparam logic [BYTE_W-1:0] CMD_DB9        = 8'd4;
  localparam logic [BYTE_W-1:0] JOY_DEV_NUMPAD = 8'h80;

  localparam logic [BYTE_W-1:0] PRESENT_ID = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_CMD   = 3'd2,
    ST_GAP   = 3'd3,
    ST_PAY   = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

  // One command frame: command byte, payload length and payload bytes (pay[0] sent first).
  typedef struct packed {
    logic [BYTE_W-1:0]                cmd;
    logic [IDX_W-1:0]                 len;
    logic [PAY_MAX-1:0][BYTE_W-1:0]   pay;
  } frame_t;

  // Number of payload bytes that follow a given command byte.
  function automatic logic [IDX_W-1:0] pay_len(input logic [BYTE_W-1:0] cmd);
    case (cmd)
      CMD_STATUS: pay_len = 3'd2;
      CMD_KBD:    pay_len = 3'd1;
      CMD_MOUSE:  pay_len = 3'd3;
      CMD_JOY:    pay_len = 3'd5;
      CMD_DB9:    pay_len = 3'd1;
      default:    pay_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/hid_cmd_sender_pacer.sv
// Inter-strobe gap counter. Loaded on every strobe cycle, counts down while the FSM
// sits in GAP and flags the final gap cycle.
//   clk, reset     clock, synchronous active-high reset
//   load_i         strobe issued this cycle; arm a fresh gap
//   en_i           FSM is in a gap cycle
//   gap_done_c_o   combinational: current gap cycle is the last one
module hid_cmd_sender_pacer #(
  parameter int unsigned STROBE_GAP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic gap_done_c_o
);

  localparam int unsigned CNT_W = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Count STROBE_GAP-1 down to 0 so the gap spans exactly STROBE_GAP cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(STROBE_GAP - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign gap_done_c_o = (cnt_q == '0);

endmodule

// File: rtl/hid_cmd_sender.sv
// Serialises keyboard/mouse/joystick events and db9 irq service into hid command frames.
//   clk, reset                     clock, synchronous active-high reset
//   kbd_* / mouse_* / joy_*        source handshakes (valid in, ready out) and payloads
//   irq / iack                     db9 change interrupt in, 1-cycle acknowledge out
//   db9_state / db9_valid          port state read by CMD 4 and its update pulse
//   hid_present                    status probe returned the hid id
//   busy                           frame in progress (selection cycle included)
//   hid_strobe/hid_start/hid_data  byte interface to hid; hid_rdata read back
module hid_cmd_sender
  import hid_cmd_sender_pkg::*;
#(
  parameter int unsigned STROBE_GAP = 4,
  parameter bit          PROBE_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_code,
  output logic       kbd_ready,
  input  logic       mouse_valid,
  input  logic [1:0] mouse_btns,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy,
  output logic       mouse_ready,
  input  logic       joy_valid,
  input  logic [7:0] joy_dev,
  input  logic [7:0] joy_dig,
  input  logic [7:0] joy_ax,
  input  logic [7:0] joy_ay,
  input  logic [7:0] joy_extra,
  output logic       joy_ready,
  input  logic       irq,
  output logic       iack,
  output logic [5:0] db9_state,
  output logic       db9_valid,
  output logic       hid_present,
  output logic       busy,
  output logic       hid_strobe,
  output logic       hid_start,
  output logic [7:0] hid_data,
  input  logic [7:0] hid_rdata
);

  state_e           state_q, state_d;
  frame_t           frame_q, frame_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             strobe_q, strobe_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic             iack_q, iack_d;
  logic             db9_valid_q, db9_valid_d;
  logic [5:0]       db9_state_q, db9_state_d;
  logic             present_q, present_d;
  logic             sel_c;
  logic             idle_c;
  logic             gap_done_c;

  hid_cmd_sender_pacer #(.STROBE_GAP(STROBE_GAP)) u_pacer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (strobe_q),
    .en_i         (state_q == ST_GAP),
    .gap_done_c_o (gap_done_c)
  );

  // Fixed-priority arbitration irq > kbd > joy > mouse; handshakes must act in the same cycle.
  assign idle_c      = !reset && (state_q == ST_IDLE);
  assign kbd_ready   = idle_c && !irq && kbd_valid;
  assign joy_ready   = idle_c && !irq && !kbd_valid && joy_valid;
  assign mouse_ready = idle_c && !irq && !kbd_valid && !joy_valid && mouse_valid;
  assign busy        = !reset && ((state_q != ST_IDLE) || sel_c);

  // Next-state, frame capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    strobe_d    = 1'b0;
    start_d     = 1'b0;
    data_d      = 8'h00;
    iack_d      = 1'b0;
    db9_valid_d = 1'b0;
    db9_state_d = db9_state_q;
    present_d   = present_q;
    sel_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (irq) begin
          sel_c       = 1'b1;
          frame_d     = '0;
          frame_d.cmd = CMD_DB9;
        end else if (kbd_valid) begin
          sel_c          = 1'b1;
          frame_d        = '0;
          frame_d.cmd    = CMD_KBD;
          frame_d.pay[0] = kbd_code;
        end else if (joy_valid) begin
          sel_c          = 1'b1;
          frame_d        = '0;
          frame_d.cmd    = CMD_JOY;
          frame_d.pay[0] = joy_dev;
          frame_d.pay[1] = joy_dig;
          frame_d.pay[2] = joy_ax;
          frame_d.pay[3] = joy_ay;
          frame_d.pay[4] = joy_extra;
        end else if (mouse_valid) begin
          sel_c          = 1'b1;
          frame_d        = '0;
          frame_d.cmd    = CMD_MOUSE;
          frame_d.pay[0] = {6'b0, mouse_btns};
          frame_d.pay[1] = mouse_dx;
          frame_d.pay[2] = mouse_dy;
        end
      end
      ST_PROBE: begin
        sel_c       = 1'b1;
        frame_d     = '0;
        frame_d.cmd = CMD_STATUS;
      end
      ST_CMD: state_d = ST_GAP;
      ST_PAY: begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_done_c) begin
          // Response of CMD0/CMD4 is readable once payload byte 0 has been strobed.
          if (idx_q == IDX_W'(1)) begin
            if (frame_q.cmd == CMD_STATUS) begin
              present_d = (hid_rdata == PRESENT_ID);
            end
            if (frame_q.cmd == CMD_DB9) begin
              db9_state_d = hid_rdata[5:0];
              db9_valid_d = 1'b1;
              iack_d      = 1'b1;
            end
          end
          if (idx_q == frame_q.len) begin
            if ((frame_q.cmd == CMD_STATUS) || (frame_q.cmd == CMD_DB9)) begin
              state_d = ST_RSP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d  = ST_PAY;
            strobe_d = 1'b1;
            data_d   = frame_q.pay[idx_q];
          end
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (sel_c) begin
      frame_d.len = pay_len(frame_d.cmd);
      state_d     = ST_CMD;
      idx_d       = '0;
      strobe_d    = 1'b1;
      start_d     = 1'b1;
      data_d      = frame_d.cmd;
    end
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PROBE_EN ? ST_PROBE : ST_IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      strobe_q    <= 1'b0;
      start_q     <= 1'b0;
      data_q      <= 8'h00;
      iack_q      <= 1'b0;
      db9_valid_q <= 1'b0;
      db9_state_q <= 6'h00;
      present_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      strobe_q    <= strobe_d;
      start_q     <= start_d;
      data_q      <= data_d;
      iack_q      <= iack_d;
      db9_valid_q <= db9_valid_d;
      db9_state_q <= db9_state_d;
      present_q   <= present_d;
    end
  end

  assign hid_strobe  = strobe_q;
  assign hid_start   = start_q;
  assign hid_data    = data_q;
  assign iack        = iack_q;
  assign db9_valid   = db9_valid_q;
  assign db9_state   = db9_state_q;
  assign hid_present = present_q;

endmodule

// File: tb/tb_hid_cmd_sender.sv
// Directed bench for hid_cmd_sender with a small hid responder model and a byte scoreboard.
module tb_hid_cmd_sender;

  localparam int unsigned GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       kbd_valid, kbd_ready;
  logic [7:0] kbd_code;
  logic       mouse_valid, mouse_ready;
  logic [1:0] mouse_btns;
  logic [7:0] mouse_dx, mouse_dy;
  logic       joy_valid, joy_ready;
  logic [7:0] joy_dev, joy_dig, joy_ax, joy_ay, joy_extra;
  logic       irq, iack;
  logic [5:0] db9_state;
  logic       db9_valid, hid_present, busy;
  logic       hid_strobe, hid_start;
  logic [7:0] hid_data, hid_rdata;

  always #5 clk = ~clk;

  hid_cmd_sender #(.STROBE_GAP(GAP), .PROBE_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .kbd_valid(kbd_valid), .kbd_code(kbd_code), .kbd_ready(kbd_ready),
    .mouse_valid(mouse_valid), .mouse_btns(mouse_btns), .mouse_dx(mouse_dx),
    .mouse_dy(mouse_dy), .mouse_ready(mouse_ready),
    .joy_valid(joy_valid), .joy_dev(joy_dev), .joy_dig(joy_dig), .joy_ax(joy_ax),
    .joy_ay(joy_ay), .joy_extra(joy_extra), .joy_ready(joy_ready),
    .irq(irq), .iack(iack), .db9_state(db9_state), .db9_valid(db9_valid),
    .hid_present(hid_present), .busy(busy),
    .hid_strobe(hid_strobe), .hid_start(hid_start), .hid_data(hid_data),
    .hid_rdata(hid_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_strobe = 0;
  int strobe_cnt  = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- hid responder model ----------------
  logic [7:0]   rcmd = 8'hFF;
  int           ridx = 0;
  logic         rvalid = 1'b0;
  logic [7:0]   rbuf [5];
  logic [127:0] key_mat = '1;
  logic [7:0]   mouse_x = 8'h00, mouse_y = 8'h00;
  logic [1:0]   mouse_b = 2'b00;
  int           mouse_cnt = 0;
  logic [7:0]   joystick0 = 8'h00, joy_numpad = 8'h00;
  int           joy_cnt = 0;
  logic [5:0]   db9_val = 6'h00;
  logic [5:0]   db9_rep = 6'h00;

  assign irq       = (db9_val != db9_rep);
  assign hid_rdata = !rvalid ? 8'h00 :
                     (rcmd == 8'd0) ? 8'h01 :
                     (rcmd == 8'd4) ? {2'b00, db9_val} : 8'h00;

  always @(posedge clk) begin
    if (iack) db9_rep <= db9_val;
    if (hid_strobe) begin
      if (hid_start) begin
        rcmd   <= hid_data;
        ridx   <= 0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= 1'b1;
        ridx   <= ridx + 1;
        if (ridx < 5) rbuf[ridx] <= hid_data;
        case (rcmd)
          8'd1: key_mat[hid_data[6:0]] <= hid_data[7];
          8'd2: begin
            if (ridx == 0) mouse_b <= hid_data[1:0];
            if (ridx == 1) mouse_x <= hid_data;
            if (ridx == 2) begin
              mouse_y   <= hid_data;
              mouse_cnt <= mouse_cnt + 1;
            end
          end
          8'd3: begin
            if (ridx == 4) begin
              if (rbuf[0] == 8'h00) joystick0 <= rbuf[1];
              if (rbuf[0] == 8'h80) joy_numpad <= rbuf[1];
              joy_cnt <= joy_cnt + 1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && hid_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_strobe_qsize", 16'(exp_q.size()), 16'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_byte", {7'b0, hid_start, hid_data}, {7'b0, mon_e});
      end
      if (!hid_start) chk("strobe_gap", 16'(cyc - last_strobe), 16'(GAP + 1));
      last_strobe = cyc;
    end
    if (!reset && (db9_valid || iack)) chk("db9v_iack_same", {14'b0, db9_valid, iack}, 16'h3);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_frame(input logic [7:0] cmd, input int n, input logic [39:0] pay);
    exp_q.push_back({1'b1, cmd});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pay[8*i +: 8]});
  endtask

  function automatic logic rdy(input int src);
    case (src)
      0:       return kbd_ready;
      1:       return joy_ready;
      default: return mouse_ready;
    endcase
  endfunction

  // Wait for the source's ready; afterwards time is just past the transfer edge.
  task automatic wait_ready(input int src, input string tag);
    int n;
    logic r;
    n = 0;
    #1;
    r = rdy(src);
    while (!r && n < 300) begin
      @(negedge clk); #1;
      n++;
      r = rdy(src);
    end
    chk(tag, 16'(r), 16'd1);
    if (r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, {14'b0, exp_q.size() == 0, busy}, 16'h2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int s0;
    reset = 1'b1;
    kbd_valid = 1'b0; kbd_code = 8'h00;
    mouse_valid = 1'b0; mouse_btns = 2'b00; mouse_dx = 8'h00; mouse_dy = 8'h00;
    joy_valid = 1'b0; joy_dev = 8'h00; joy_dig = 8'h00; joy_ax = 8'h00;
    joy_ay = 8'h00; joy_extra = 8'h00;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_flags", 16'({hid_strobe, hid_start, busy, iack, db9_valid, hid_present,
                          kbd_ready, joy_ready, mouse_ready}), 16'd0);
    chk("rst_hid_data", 16'(hid_data), 16'h00);
    chk("rst_db9_state", 16'(db9_state), 16'h00);

    // Status probe after reset.
    push_frame(8'h00, 2, 40'h0);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!hid_present && n < 60);
    chk("probe_present", 16'(hid_present), 16'd1);
    chk("probe_latency", 16'(n), 16'd11);
    wait_idle("probe_idle");

    // Keyboard press then release of 'A'.
    kbd_code = 8'h04; kbd_valid = 1'b1;
    push_frame(8'h01, 1, 40'h04);
    wait_ready(0, "kbd_press_ready");
    kbd_valid = 1'b0;
    wait_idle("kbd_press_idle");
    chk("key_a_pressed", 16'(key_mat[4]), 16'd0);
    kbd_code = 8'h84; kbd_valid = 1'b1;
    push_frame(8'h01, 1, 40'h84);
    wait_ready(0, "kbd_release_ready");
    kbd_valid = 1'b0;
    wait_idle("kbd_release_idle");
    chk("key_a_released", 16'(key_mat[4]), 16'd1);

    // Mouse event.
    mouse_btns = 2'b01; mouse_dx = 8'h05; mouse_dy = 8'hFB; mouse_valid = 1'b1;
    push_frame(8'h02, 3, {16'h0, 8'hFB, 8'h05, 8'h01});
    wait_ready(2, "mouse_ready");
    mouse_valid = 1'b0;
    wait_idle("mouse_idle");
    chk("mouse_xy", {mouse_x, mouse_y}, 16'h05FB);
    chk("mouse_btn", 16'(mouse_b), 16'h1);
    chk("mouse_cnt", 16'(mouse_cnt), 16'd1);

    // Joystick 0 event: six strobes.
    s0 = strobe_cnt;
    joy_dev = 8'h00; joy_dig = 8'h1F; joy_ax = 8'h80; joy_ay = 8'h7F; joy_extra = 8'h01;
    joy_valid = 1'b1;
    push_frame(8'h03, 5, {8'h01, 8'h7F, 8'h80, 8'h1F, 8'h00});
    wait_ready(1, "joy_ready");
    joy_valid = 1'b0;
    wait_idle("joy_idle");
    chk("joystick0", 16'(joystick0), 16'h1F);
    chk("joy_cnt1", 16'(joy_cnt), 16'd1);
    chk("joy_strobes", 16'(strobe_cnt - s0), 16'd6);

    // db9 change -> CMD4 service.
    @(negedge clk); #1;
    db9_val = 6'h2A;
    push_frame(8'h04, 1, 40'h0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!db9_valid && n < 100);
    chk("db9_valid_seen", 16'(db9_valid), 16'd1);
    chk("db9_state_2a", 16'(db9_state), 16'h2A);
    chk("db9_iack", 16'(iack), 16'd1);
    @(negedge clk); #1;
    chk("irq_dropped", 16'({irq, iack, db9_valid}), 16'd0);
    wait_idle("db9_idle");

    // Simultaneous irq, kbd, joy -> CMD4, CMD1, CMD3.
    @(negedge clk); #1;
    db9_val = 6'h15;
    kbd_code = 8'h05; kbd_valid = 1'b1;
    joy_dev = 8'h80; joy_dig = 8'h3C; joy_ax = 8'h11; joy_ay = 8'h22; joy_extra = 8'h33;
    joy_valid = 1'b1;
    push_frame(8'h04, 1, 40'h0);
    push_frame(8'h01, 1, 40'h05);
    push_frame(8'h03, 5, {8'h33, 8'h22, 8'h11, 8'h3C, 8'h80});
    #1;
    chk("arb_irq_wins", 16'({kbd_ready, joy_ready, busy}), 16'h1);
    wait_ready(0, "arb_kbd_ready");
    kbd_valid = 1'b0;
    wait_ready(1, "arb_joy_ready");
    joy_valid = 1'b0;
    wait_idle("arb_idle");
    chk("arb_db9_state", 16'(db9_state), 16'h15);
    chk("arb_key5", 16'(key_mat[5]), 16'd0);
    chk("arb_numpad", 16'(joy_numpad), 16'h3C);
    chk("arb_joy_cnt", 16'(joy_cnt), 16'd2);

    // Reset in the middle of a CMD3 frame.
    joy_dev = 8'h00; joy_dig = 8'h55; joy_ax = 8'h01; joy_ay = 8'h02; joy_extra = 8'h03;
    joy_valid = 1'b1;
    push_frame(8'h03, 5, {8'h03, 8'h02, 8'h01, 8'h55, 8'h00});
    wait_ready(1, "mid_joy_ready");
    joy_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_three_left", 16'(exp_q.size()), 16'd3);
    reset = 1'b1;
    exp_q.delete();
    push_frame(8'h00, 2, 40'h0);
    @(negedge clk); #1;
    chk("mid_rst_flags", 16'({hid_strobe, hid_start, busy, iack, db9_valid, hid_present}), 16'd0);
    chk("mid_rst_data", 16'(hid_data), 16'h00);
    chk("mid_rst_db9", 16'(db9_state), 16'h00);
    @(negedge clk); #1;
    reset = 1'b0;
    wait_idle("reprobe_idle");
    chk("reprobe_present", 16'(hid_present), 16'd1);
    chk("mid_joy_dropped", 16'(joy_cnt), 16'd2);
    chk("mid_joystick0", 16'(joystick0), 16'h1F);

    // Next frame after reset decodes correctly.
    mouse_btns = 2'b10; mouse_dx = 8'h80; mouse_dy = 8'h7F; mouse_valid = 1'b1;
    push_frame(8'h02, 3, {16'h0, 8'h7F, 8'h80, 8'h02});
    wait_ready(2, "post_mouse_ready");
    mouse_valid = 1'b0;
    wait_idle("post_mouse_idle");
    chk("post_mouse_xy", {mouse_x, mouse_y}, 16'h807F);
    chk("post_mouse_cnt", 16'(mouse_cnt), 16'd2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
